// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A requester keeps the grant while it keeps requesting, for at most HOLD_MAX
// consecutive cycles. After that the grant passes to the next requester in
// rotating-priority order, with no idle cycle in between.
//
// Ports:
//   CLK  - rising-edge clock
//   RST  - synchronous active-high reset
//   REQ  - level-sensitive request lines, one per requester
//   GNT  - registered one-hot grant, zero when nobody owns the resource
//   ANY  - combinational OR of REQ
//   BUSY - registered, high while a grant is held
//   VDD/VSS - supply pins, carry no logic
module gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       ANY,
  output logic       BUSY,
  inout  wire        VDD,
  inout  wire        VSS
);

  localparam int unsigned HCNT_W = $clog2(HOLD_MAX);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD_MAX - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;

  logic [2:0]        pick;      // {found, index}
  logic [3:0]        others;
  logic [1:0]        owner;
  logic              own_req;

  // Supply pins are tied off into a dead net so they are not left dangling.
  wire unused_pwr = VDD ^ VSS;

  // First asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Index of the set bit of a one-hot vector.
  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) res = 2'(i);
    end
    return res;
  endfunction

  assign ANY  = |REQ;
  assign GNT  = gnt_q;
  assign BUSY = busy_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    pick    = 3'b000;
    others  = 4'b0000;
    owner   = enc(gnt_q);
    own_req = |(REQ & gnt_q);

    case (state_q)
      ST_IDLE: begin
        pick = rr_pick(REQ, ptr_q);
        if (pick[2]) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          busy_d  = 1'b1;
          hcnt_d  = '0;
          ptr_d   = pick[1:0] + 2'd1;
        end else begin
          gnt_d  = 4'b0000;
          busy_d = 1'b0;
        end
      end

      ST_GRANT: begin
        // The current owner never competes in its own handoff scan.
        others = REQ & ~gnt_q;
        pick   = rr_pick(others, ptr_q);
        if (own_req && (hcnt_q != HCNT_LAST)) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end else if (pick[2]) begin
          gnt_d  = 4'b0001 << pick[1:0];
          hcnt_d = '0;
          ptr_d  = pick[1:0] + 2'd1;
        end else if (!own_req) begin
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end else begin
          // Timed out with nobody else waiting: restart the same owner.
          hcnt_d = '0;
          ptr_d  = owner + 2'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1.sv
// Bench for the four-requester round-robin arbiter: directed scenarios
// followed by random requests, all compared against an integer-level model.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb4_1;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       any;
  logic       busy;
  wire        vdd;
  wire        vss;

  assign vdd = 1'b1;
  assign vss = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference state: owner index (-1 when idle), priority start, cycles held minus one.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  gf180mcu_fd_sc_mcu9t5v0__rrarb4_1 #(.HOLD_MAX(HOLD)) dut (
    .CLK (clk),
    .RST (rst),
    .REQ (req),
    .GNT (gnt),
    .ANY (any),
    .BUSY(busy),
    .VDD (vdd),
    .VSS (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Nearest asserted request at or after 'from' in circular order, skipping 'excl'.
  function automatic int pick(input logic [3:0] r, input int from, input int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  // Advance the reference by one rising edge using the inputs seen at that edge.
  task automatic model_edge(input logic r_rst, input logic [3:0] r_req);
    int w;
    if (r_rst) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
    end else if (m_owner < 0) begin
      w = pick(r_req, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_held = 0; m_ptr = (w + 1) % 4;
      end
    end else if (r_req[m_owner] && m_held < HOLD - 1) begin
      m_held++;
    end else begin
      w = pick(r_req, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w; m_held = 0; m_ptr = (w + 1) % 4;
      end else if (!r_req[m_owner]) begin
        m_owner = -1;
      end else begin
        m_held = 0; m_ptr = (m_owner + 1) % 4;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    model_edge(rst, req);
    #1;
    chk("gnt", 8'(gnt), 8'(exp_gnt()));
    chk("busy", 8'(busy), 8'(m_owner >= 0));
    chk("any", 8'(any), 8'(|req));
    chk("onehot", 8'($onehot0(gnt)), 8'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int run;
    int max_run;
    logic [3:0] prev_gnt;
    logic [3:0] req_at_edge;

    rst = 1'b1;
    req = 4'b0000;

    // Reset with requests present: they must be ignored.
    req = 4'b1111;
    step();
    step();
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    rst = 1'b0;

    // All four requesting: eight cycles each, rotating, no gap.
    for (int n = 1; n <= 33; n++) begin
      step();
      chk("rr_all", 8'(gnt), 8'(4'b0001 << (((n - 1) / HOLD) % 4)));
    end

    // Single short request then release.
    do_reset();
    req = 4'b0100;
    for (int n = 1; n <= 3; n++) begin
      step();
      chk("short_gnt", 8'(gnt), 8'h04);
    end
    req = 4'b0000;
    step();
    chk("short_rel_gnt", 8'(gnt), 8'h00);
    chk("short_rel_busy", 8'(busy), 8'h00);
    chk("short_ptr", 8'(dut.ptr_q), 8'd3);

    // Lone requester held: timeout re-grants the same owner, counter restarts.
    do_reset();
    req = 4'b0001;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk("lone_gnt", 8'(gnt), 8'h01);
      chk("lone_busy", 8'(busy), 8'h01);
      chk("lone_hcnt", 8'(dut.hcnt_q), 8'((n - 1) % HOLD));
    end

    // Owner 1 drops while 0 and 3 request: scan starts at 2, so 3 wins.
    do_reset();
    req = 4'b0010;
    step();
    chk("own1", 8'(gnt), 8'h02);
    req = 4'b1001;
    step();
    chk("handoff", 8'(gnt), 8'h08);

    // Reset in the middle of a grant.
    do_reset();
    req = 4'b1111;
    for (int n = 1; n <= HOLD + 1; n++) step();
    chk("mid_gnt", 8'(gnt), 8'h02);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", 8'(gnt), 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    rst = 1'b0;
    step();
    chk("post_rst", 8'(gnt), 8'h01);

    // Random traffic: requests mostly stable, occasional change or reset.
    do_reset();
    run = 0;
    max_run = 0;
    prev_gnt = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      req_at_edge = req;
      step();
      if (!rst && gnt != 4'b0000 && gnt == prev_gnt && (req_at_edge & ~gnt) != 4'b0000)
        run++;
      else
        run = 0;
      if (run > max_run) max_run = run;
      prev_gnt = gnt;
    end
    rst = 1'b0;
    chk("fair_hold", 8'(max_run <= HOLD), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
